// File: rtl/avmm_dmem_slave.sv
// Avalon-MM responder for the CPU data-memory window: single-port word RAM with
// byte-enabled writes and in-order, fixed-latency pipelined read responses.
module avmm_dmem_slave #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              avs_waitrequest,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic              avs_readdatavalid,
    output logic [31:0]       avs_readdata
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    logic                  ready_q;
    logic [PEND_W-1:0]     pending;
    logic [31:0]           mem [MEM_WORDS];
    logic [RD_LATENCY-1:0] vld_q;
    logic [31:0]           dat_q [RD_LATENCY];
    logic                  rd_accept;
    logic                  wr_accept;
    logic [IDX_W-1:0]      word_idx;
    logic                  unused_addr;

    // Backpressure depends only on registered state, never on this cycle's response.
    assign avs_waitrequest = ~ready_q | (pending == PEND_W'(MAX_PENDING));

    // A simultaneous read+write is illegal; the write wins and the read is dropped.
    assign wr_accept = avs_write & ~avs_waitrequest;
    assign rd_accept = avs_read & ~avs_write & ~avs_waitrequest;

    // Upper address bits are ignored, so the RAM aliases across the window.
    assign word_idx    = avs_address[IDX_W+1:2];
    assign unused_addr = ^{avs_address[ADDR_W-1:IDX_W+2], avs_address[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < 4; i++) begin
                if (avs_byteenable[i]) begin
                    mem[word_idx][8*i +: 8] <= avs_writedata[8*i +: 8];
                end
            end
        end
    end

    // Data stages only advance behind a valid, so the last stage holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_accept;
            if (rd_accept) begin
                dat_q[0] <= mem[word_idx];
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign avs_readdatavalid = vld_q[RD_LATENCY-1];
    assign avs_readdata      = dat_q[RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            case ({rd_accept, avs_readdatavalid})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    a_no_rd_wr_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(avs_read && avs_write));

endmodule

// File: tb/tb_avmm_dmem_slave.sv
// Directed self-checking bench for avmm_dmem_slave: default instance plus a
// MAX_PENDING=2 instance for backpressure scenarios.
module tb_avmm_dmem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        wreq, rdv, wr, rd;
    logic [23:0] addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  be;

    logic        wreq2, rdv2, wr2, rd2;
    logic [23:0] addr2;
    logic [31:0] wdata2, rdata2;
    logic [3:0]  be2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avmm_dmem_slave #(.ADDR_W(24), .MEM_WORDS(4096), .RD_LATENCY(2), .MAX_PENDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .avs_waitrequest(wreq), .avs_write(wr), .avs_read(rd),
        .avs_address(addr), .avs_writedata(wdata), .avs_byteenable(be),
        .avs_readdatavalid(rdv), .avs_readdata(rdata)
    );

    avmm_dmem_slave #(.ADDR_W(24), .MEM_WORDS(4096), .RD_LATENCY(2), .MAX_PENDING(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .avs_waitrequest(wreq2), .avs_write(wr2), .avs_read(rd2),
        .avs_address(addr2), .avs_writedata(wdata2), .avs_byteenable(be2),
        .avs_readdatavalid(rdv2), .avs_readdata(rdata2)
    );

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] b,
                             output int waits);
        waits = 0;
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d; be = b;
        while (wreq === 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic read_check(input logic [23:0] a, input logic [31:0] exp, input string nm);
        int waits = 0;
        int lat = 0;
        @(negedge clk);
        rd = 1'b1; addr = a;
        while (wreq === 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        checks++;
        if (waits !== 0) begin
            errors++; $display("FAIL %s_wait: waited %0d cycles, expected 0", nm, waits);
        end
        do begin
            @(negedge clk);
            lat++;
        end while (rdv !== 1'b1 && lat < 10);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL %s_latency: got %0d expected 2", nm, lat);
        end
        checks++;
        if (rdata !== exp) begin
            errors++; $display("FAIL %s_data: got %h expected %h", nm, rdata, exp);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (wreq !== 1'b1 || rdv !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: wreq=%b rdv=%b rdata=%h expected 1 0 0", wreq, rdv, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (wreq !== 1'b1) begin
            errors++; $display("FAIL reset_release_wreq: got %b expected 1", wreq);
        end
        @(negedge clk);
        checks++;
        if (wreq !== 1'b0 || wreq2 !== 1'b0) begin
            errors++; $display("FAIL reset_ready: wreq=%b wreq2=%b expected 0 0", wreq, wreq2);
        end
    endtask

    task automatic test_basic;
        int w;
        bus_write(24'h10, 32'h1234_5678, 4'hF, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL basic_write_wait: waited %0d expected 0", w);
        end
        read_check(24'h10, 32'h1234_5678, "basic");
        @(negedge clk);
        checks++;
        if (rdv !== 1'b0 || rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL basic_hold: rdv=%b rdata=%h expected 0 12345678", rdv, rdata);
        end
    endtask

    task automatic test_byteenable;
        int w;
        bus_write(24'h20, 32'hFFFF_FFFF, 4'hF, w);
        bus_write(24'h20, 32'h0000_00AB, 4'b0001, w);
        read_check(24'h20, 32'hFFFF_FFAB, "be_lane0");
        bus_write(24'h20, 32'h1234_5678, 4'h0, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL be_zero_wait: waited %0d expected 0", w);
        end
        read_check(24'h20, 32'hFFFF_FFAB, "be_zero");
    endtask

    task automatic test_back_to_back;
        int w;
        int wq = 0;
        int n = 0;
        logic [31:0] got [8];
        int at [8];
        for (int i = 0; i < 8; i++) begin
            bus_write(24'(i * 4), 32'h0B0B_0000 + 32'(i), 4'hF, w);
        end
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    rd = 1'b1; addr = 24'(i * 4);
                    if (wreq === 1'b1) wq++;
                    @(posedge clk);
                    #1;
                end
                rd = 1'b0;
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    #1;
                    if (rdv === 1'b1 && n < 8) begin
                        got[n] = rdata; at[n] = c; n++;
                    end
                end
            end
        join
        checks++;
        if (wq !== 0) begin
            errors++; $display("FAIL b2b_wait: waitrequest seen %0d times expected 0", wq);
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL b2b_count: got %0d responses expected 8", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got[k] !== 32'h0B0B_0000 + 32'(k) || at[k] !== k + 2) begin
                errors++;
                $display("FAIL b2b_resp%0d: data %h at cycle %0d expected %h at cycle %0d",
                         k, got[k], at[k], 32'h0B0B_0000 + 32'(k), k + 2);
            end
        end
    endtask

    task automatic test_pending_limit;
        int pend = 0;
        int wq_seen = 0;
        int n = 0;
        int bad = 0;
        logic [31:0] got [6];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr2 = 1'b1; addr2 = 24'(i * 4); wdata2 = 32'h5A00_0000 + 32'(i); be2 = 4'hF;
            @(posedge clk);
            #1;
            wr2 = 1'b0;
        end
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int g = 0;
                    @(negedge clk);
                    rd2 = 1'b1; addr2 = 24'(i * 4);
                    while (wreq2 === 1'b1 && g < 20) begin
                        @(negedge clk);
                        g++;
                    end
                    @(posedge clk);
                    #1;
                end
                rd2 = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    logic acc;
                    @(negedge clk);
                    #1;
                    acc = rd2 & ~wreq2;
                    checks++;
                    if (wreq2 !== (pend == 2)) begin
                        errors++; bad++;
                        if (bad < 4) $display("FAIL pend_wreq: cycle %0d wreq=%b model pending=%0d", c, wreq2, pend);
                    end
                    if (wreq2 === 1'b1) wq_seen++;
                    if (rdv2 === 1'b1) begin
                        if (n < 6) got[n] = rdata2;
                        n++;
                    end
                    pend = pend + int'(acc) - int'(rdv2);
                end
            end
        join
        checks++;
        if (wq_seen == 0) begin
            errors++; $display("FAIL pend_backpressure: waitrequest never asserted, expected some");
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL pend_count: got %0d responses expected 6", n);
        end
        for (int k = 0; k < 6 && k < n; k++) begin
            checks++;
            if (got[k] !== 32'h5A00_0000 + 32'(k)) begin
                errors++; $display("FAIL pend_data%0d: got %h expected %h", k, got[k], 32'h5A00_0000 + 32'(k));
            end
        end
        checks++;
        if (pend !== 0 || wreq2 !== 1'b0) begin
            errors++; $display("FAIL pend_drain: model pending=%0d wreq=%b expected 0 0", pend, wreq2);
        end
    endtask

    task automatic test_reset_midop;
        int pulses = 0;
        @(negedge clk);
        rd = 1'b1; addr = 24'h20;
        @(posedge clk);
        #1;
        addr = 24'h10;
        @(posedge clk);
        #1;
        rd = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdv !== 1'b0 || wreq !== 1'b1) begin
            errors++; $display("FAIL midrst_immediate: rdv=%b wreq=%b expected 0 1", rdv, wreq);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (wreq !== 1'b1) begin
            errors++; $display("FAIL midrst_release_wreq: got %b expected 1", wreq);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (wreq !== 1'b0) begin
                    errors++; $display("FAIL midrst_ready: wreq=%b expected 0", wreq);
                end
            end
            if (rdv === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midrst_stale: got %0d pulses expected 0", pulses);
        end
        read_check(24'h20, 32'hFFFF_FFAB, "midrst_retain");
    endtask

    task automatic test_alias;
        int w;
        bus_write(24'h00_0004, 32'hCAFE_F00D, 4'hF, w);
        read_check(24'h00_4004, 32'hCAFE_F00D, "alias");
    endtask

    initial begin
        wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; be = '0;
        wr2 = 1'b0; rd2 = 1'b0; addr2 = '0; wdata2 = '0; be2 = '0;
        test_reset();
        test_basic();
        test_byteenable();
        test_back_to_back();
        test_pending_limit();
        test_reset_midop();
        test_alias();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
